// File: rtl/imem_ctrl.sv
// Instruction-memory controller: assembles aligned 32-bit little-endian fetches
// from a byte-wide single-port memory and shares that port with a byte loader.
module imem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_ready,
  output logic              f_valid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [7:0]        l_wdata,
  output logic              l_ack,
  output logic              l_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, FISSUE, FLAST, FRESP, FERR, LWRITE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic              r_last_grant;  // 1: loader was granted last
  logic [23:0]       r_word;
  logic [31:0]       r_rdata;

  logic              w_grant_f;
  logic              w_grant_l;
  logic              w_f_ok;
  logic              w_l_ok;

  function automatic logic in_range(input logic [31:0] a);
    return (a >> ADDR_W) == 32'd0;
  endfunction

  // Round-robin: fetch wins a tie only when the loader had the last grant.
  assign w_grant_f = f_req && (!l_req || r_last_grant);
  assign w_grant_l = l_req && !w_grant_f;
  assign w_f_ok    = in_range(f_addr) && (f_addr[1:0] == 2'b00);
  assign w_l_ok    = in_range(l_addr);

  assign f_rdata = r_rdata;
  assign busy    = (r_state != IDLE);

  always_comb begin
    w_next    = r_state;
    f_ready   = 1'b0;
    f_valid   = 1'b0;
    f_err     = 1'b0;
    l_ack     = 1'b0;
    l_err     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (r_state)
      IDLE: begin
        if (w_grant_f) begin
          f_ready = 1'b1;
          w_next  = w_f_ok ? FISSUE : FERR;
        end else if (w_grant_l) begin
          w_next = LWRITE;
        end
      end
      FISSUE: begin
        mem_addr = r_base + ADDR_W'(r_cnt);
        if (r_cnt == 2'd3) w_next = FLAST;
      end
      FLAST: w_next = FRESP;
      FRESP: begin
        f_valid = 1'b1;
        w_next  = IDLE;
      end
      FERR: begin
        f_valid = 1'b1;
        f_err   = 1'b1;
        w_next  = IDLE;
      end
      LWRITE: begin
        l_ack  = 1'b1;
        w_next = IDLE;
        if (w_l_ok) begin
          mem_we    = 1'b1;
          mem_addr  = l_addr[ADDR_W-1:0];
          mem_wdata = l_wdata;
        end else begin
          l_err = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 2'd0;
      r_last_grant <= 1'b1;
      r_rdata      <= 32'h0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_cnt <= 2'd0;
          if (w_grant_f) begin
            r_last_grant <= 1'b0;
            if (!w_f_ok) r_rdata <= 32'h0;
          end else if (w_grant_l) begin
            r_last_grant <= 1'b1;
          end
        end
        FISSUE: r_cnt <= r_cnt + 2'd1;
        // Lane 3 arrives while in FLAST; publish the whole word at once so
        // f_rdata only ever changes when a response is produced.
        FLAST:  r_rdata <= {mem_rdata, r_word};
        default: ;
      endcase
    end
  end

  // Byte assembly: the memory answers one cycle after the address, so the
  // byte for lane cnt-1 is on mem_rdata while cnt is presented.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_grant_f) r_base <= f_addr[ADDR_W-1:0];
    if (r_state == FISSUE) begin
      case (r_cnt)
        2'd1:    r_word[7:0]   <= mem_rdata;
        2'd2:    r_word[15:8]  <= mem_rdata;
        2'd3:    r_word[23:16] <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: byte memory model, request drivers that push expected
// responses to a scoreboard, and a monitor that pops and compares them.
`timescale 1ns/1ps
module tb_imem_ctrl;
  localparam int ADDR_W = 8;
  localparam int NV = 21;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_req, f_ready, f_valid, f_err;
  logic [31:0]       f_addr, f_rdata;
  logic              l_req, l_ack, l_err;
  logic [31:0]       l_addr;
  logic [7:0]        l_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              busy;

  imem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_valid(f_valid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack), .l_err(l_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                is_fetch;
    bit                err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    int                t_acc;
    int                lat;
  } exp_t;

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [7:0]  wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[NV];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [31:0] hold_rd = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input bit err, input logic [31:0] rd,
                          input bit push, output int t_acc);
    exp_t e;
    bit   got;
    f_req = 1'b1;
    f_addr = a;
    got = 1'b0;
    t_acc = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      #1;
      if (f_ready) begin
        got = 1'b1;
        t_acc = cyc;
        if (push) begin
          e.is_fetch = 1'b1; e.err = err; e.rdata = err ? 32'h0 : rd;
          e.waddr = '0; e.wdata = 8'h00; e.t_acc = cyc; e.lat = err ? 1 : 6;
          sb.push_back(e);
        end
        @(posedge clk);
      end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL fetch_accept_timeout: addr 0x%0h never accepted", a);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] d, input bit err,
                          output int t_acc);
    exp_t e;
    bit   got;
    l_req = 1'b1;
    l_addr = a;
    l_wdata = d;
    got = 1'b0;
    t_acc = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      #1;
      if (!busy && !f_ready && !reset) begin
        got = 1'b1;
        t_acc = cyc;
        e.is_fetch = 1'b0; e.err = err; e.rdata = 32'h0;
        e.waddr = a[ADDR_W-1:0]; e.wdata = d; e.t_acc = cyc; e.lat = 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
      end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL write_accept_timeout: addr 0x%0h never accepted", a);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL response_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (reset) hold_rd = 32'h0;
      if (mon_en) begin
        if (f_valid || l_ack) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_response: f_valid=%0b l_ack=%0b at cycle %0d, required none",
                     f_valid, l_ack, cyc);
          end else begin
            e = sb.pop_front();
            if (e.is_fetch) begin
              check("f_valid", 32'(f_valid), 32'd1);
              check("l_ack_in_fetch", 32'(l_ack), 32'd0);
              check("f_err", 32'(f_err), 32'(e.err));
              check("f_rdata", f_rdata, e.rdata);
              check("fetch_latency", 32'(cyc - e.t_acc), 32'(e.lat));
              hold_rd = e.rdata;
            end else begin
              check("l_ack", 32'(l_ack), 32'd1);
              check("f_valid_in_write", 32'(f_valid), 32'd0);
              check("l_err", 32'(l_err), 32'(e.err));
              check("mem_we", 32'(mem_we), 32'(!e.err));
              if (!e.err) begin
                check("mem_addr_write", 32'(mem_addr), 32'(e.waddr));
                check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
              end
              check("write_latency", 32'(cyc - e.t_acc), 32'(e.lat));
            end
          end
        end else begin
          check("f_rdata_hold", f_rdata, hold_rd);
          if (mem_we) begin
            n_checks++; n_fail++;
            $display("FAIL stray_mem_we: mem_we=1 outside a write at cycle %0d, required 0", cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int tr, tf1, tf2, tl1, tl2, ta, tb2;
    reset = 1'b1; f_req = 1'b0; f_addr = 32'h0;
    l_req = 1'b0; l_addr = 32'h0; l_wdata = 8'h00;

    vt[0]  = '{1'b1, 32'h0000_0000, 8'h13, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 32'h0000_0001, 8'h01, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 32'h0000_0002, 8'h50, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 32'h0000_0003, 8'h00, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 32'h0050_0113};
    vt[5]  = '{1'b0, 32'h0000_0002, 8'h00, 1'b1, 32'h0};
    vt[6]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b1, 32'h0};
    vt[7]  = '{1'b1, 32'h0000_0100, 8'hA5, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 32'h0000_0004, 8'hEF, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 32'h0000_0005, 8'hBE, 1'b0, 32'h0};
    vt[10] = '{1'b1, 32'h0000_0006, 8'hAD, 1'b0, 32'h0};
    vt[11] = '{1'b1, 32'h0000_0007, 8'hDE, 1'b0, 32'h0};
    vt[12] = '{1'b0, 32'h0000_0004, 8'h00, 1'b0, 32'hDEAD_BEEF};
    vt[13] = '{1'b1, 32'h0000_00FC, 8'h78, 1'b0, 32'h0};
    vt[14] = '{1'b1, 32'h0000_00FD, 8'h56, 1'b0, 32'h0};
    vt[15] = '{1'b1, 32'h0000_00FE, 8'h34, 1'b0, 32'h0};
    vt[16] = '{1'b1, 32'h0000_00FF, 8'h12, 1'b0, 32'h0};
    vt[17] = '{1'b0, 32'h0000_00FC, 8'h00, 1'b0, 32'h1234_5678};
    vt[18] = '{1'b0, 32'h0000_0001, 8'h00, 1'b1, 32'h0};
    vt[19] = '{1'b0, 32'h8000_0000, 8'h00, 1'b1, 32'h0};
    vt[20] = '{1'b0, 32'h0000_0000, 8'h00, 1'b0, 32'h0050_0113};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_f_valid", 32'(f_valid), 32'd0);
    check("rst_f_err", 32'(f_err), 32'd0);
    check("rst_l_ack", 32'(l_ack), 32'd0);
    check("rst_l_err", 32'(l_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_f_rdata", f_rdata, 32'h0);
    check("rst_f_ready", 32'(f_ready), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].is_load) begin
        do_write(vt[i].addr, vt[i].wdata, vt[i].err, tr);
        l_req = 1'b0;
      end else begin
        do_fetch(vt[i].addr, vt[i].err, vt[i].rdata, 1'b1, tr);
        f_req = 1'b0;
      end
      wait_drain();
    end

    // Both requesters held high straight out of reset: fetch, loader, fetch, loader.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fork
      begin
        do_fetch(32'h0, 1'b0, 32'h0050_0113, 1'b1, tf1);
        do_fetch(32'h4, 1'b0, 32'hDEAD_BEEF, 1'b1, tf2);
        f_req = 1'b0;
      end
      begin
        do_write(32'h10, 8'hAA, 1'b0, tl1);
        do_write(32'h11, 8'hBB, 1'b0, tl2);
        l_req = 1'b0;
      end
    join
    wait_drain();
    check("arb_loader_after_fetch", 32'(tl1 - tf1), 32'd7);
    check("arb_fetch_after_loader", 32'(tf2 - tl1), 32'd2);
    check("arb_loader_again", 32'(tl2 - tf2), 32'd7);

    // Back-to-back fetches with f_req held: second accept exactly 7 cycles later.
    do_fetch(32'h0, 1'b0, 32'h0050_0113, 1'b1, ta);
    do_fetch(32'h4, 1'b0, 32'hDEAD_BEEF, 1'b1, tb2);
    f_req = 1'b0;
    wait_drain();
    check("b2b_accept_gap", 32'(tb2 - ta), 32'd7);

    // Reset in T+3 of a fetch: no response, controller idle next cycle.
    do_fetch(32'hFC, 1'b0, 32'h0, 1'b0, tr);
    f_req = 1'b0;
    check("midfetch_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_abort_busy", 32'(busy), 32'd0);
    check("rst_abort_f_valid", 32'(f_valid), 32'd0);
    check("rst_abort_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_abort_f_rdata", f_rdata, 32'h0);
    repeat (10) @(negedge clk);
    check("rst_abort_idle_later", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
